// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a serializer; a non-empty FIFO pops one cycle after the write.
// No backpressure: writes to a full FIFO with no same-cycle pop are dropped and flagged by a sticky overrun.
module uart_tx_fifo #(
  parameter int FIFO_LENGTH   = 8,
  parameter int DIVISOR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        divisor_set,
  input  logic [31:0] divisor_reg,
  input  logic        tx_en_in,
  input  logic [7:0]  tx_char_in,
  output logic        tx_fifo_full_out,
  output logic        tx_fifo_empty_out,
  output logic        tx_busy_out,
  output logic        tx_overrun_out,
  input  logic        tx_overrun_clear,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_LENGTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_LENGTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]               mem [FIFO_LENGTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [DIVISOR_WIDTH-1:0] clocks_per_bit;
  logic [DIVISOR_WIDTH-1:0] frame_div;
  logic [DIVISOR_WIDTH-1:0] cyc_cnt;
  logic [1:0]               state;
  logic [2:0]               bit_cnt;
  logic [7:0]               shift_reg;
  logic                     tx_q;
  logic                     overrun_q;

  logic fifo_empty;
  logic fifo_full;
  logic bit_done;
  logic pop;
  logic push;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign bit_done   = (cyc_cnt == '0);
  assign pop  = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_done));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the write
  assign push = tx_en_in && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      clocks_per_bit <= DIVISOR_WIDTH'(1);
    end else if (divisor_set) begin
      clocks_per_bit <= (divisor_reg[DIVISOR_WIDTH-1:0] == '0) ? DIVISOR_WIDTH'(1)
                                                             : divisor_reg[DIVISOR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_char_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (tx_en_in && fifo_full && !pop) begin
      overrun_q <= 1'b1;
    end else if (tx_overrun_clear) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tx_q      <= 1'b1;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      frame_div <= DIVISOR_WIDTH'(1);
    end else begin
      case (state)
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            tx_q    <= shift_reg[0];
            bit_cnt <= '0;
            cyc_cnt <= frame_div - DIVISOR_WIDTH'(1);
          end else begin
            cyc_cnt <= cyc_cnt - DIVISOR_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cyc_cnt <= frame_div - DIVISOR_WIDTH'(1);
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_q      <= shift_reg[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt - DIVISOR_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (!pop) state <= S_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt - DIVISOR_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // Frame start from IDLE or straight out of STOP; divisor is frozen for the whole frame
      if (pop) begin
        state     <= S_START;
        shift_reg <= mem[rd_ptr];
        frame_div <= clocks_per_bit;
        cyc_cnt   <= clocks_per_bit - DIVISOR_WIDTH'(1);
        tx_q      <= 1'b0;
      end
    end
  end

  assign tx_fifo_full_out  = fifo_full;
  assign tx_fifo_empty_out = fifo_empty;
  assign tx_busy_out       = (state != S_IDLE) || !fifo_empty;
  assign tx_overrun_out    = overrun_q;
  assign uart_tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        divisor_set;
  logic [31:0] divisor_reg;
  logic        tx_en_in;
  logic [7:0]  tx_char_in;
  logic        tx_fifo_full_out;
  logic        tx_fifo_empty_out;
  logic        tx_busy_out;
  logic        tx_overrun_out;
  logic        tx_overrun_clear;
  logic        uart_tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.FIFO_LENGTH(8), .DIVISOR_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .divisor_set       (divisor_set),
    .divisor_reg       (divisor_reg),
    .tx_en_in          (tx_en_in),
    .tx_char_in        (tx_char_in),
    .tx_fifo_full_out  (tx_fifo_full_out),
    .tx_fifo_empty_out (tx_fifo_empty_out),
    .tx_busy_out       (tx_busy_out),
    .tx_overrun_out    (tx_overrun_out),
    .tx_overrun_clear  (tx_overrun_clear),
    .uart_tx           (uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level for bit slot idx of an 8N1 frame (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; divisor_set = 1'b0; divisor_reg = '0;
    tx_en_in = 1'b0; tx_char_in = '0; tx_overrun_clear = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_div(input int d);
    divisor_set = 1'b1; divisor_reg = d;
    step();
    divisor_set = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    if (tx_fifo_empty_out !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", tx_fifo_empty_out); end
    if (tx_fifo_full_out !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", tx_fifo_full_out); end
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy_out); end
    if (tx_overrun_out !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", tx_overrun_out); end
  endtask

  task automatic test_single_frame();
    do_reset();
    set_div(4);
    tx_en_in = 1'b1; tx_char_in = 8'h55;
    step();
    tx_en_in = 1'b0;
    checks += 2;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t1_prestart_tx: got %b expected 1", uart_tx); end
    if (tx_fifo_empty_out !== 1'b0) begin failures++; $display("FAIL t1_prestart_empty: got %b expected 0", tx_fifo_empty_out); end
    step();
    checks += 2;
    if (tx_fifo_empty_out !== 1'b1) begin failures++; $display("FAIL t1_popped_empty: got %b expected 1", tx_fifo_empty_out); end
    if (tx_busy_out !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b expected 1", tx_busy_out); end
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      checks++;
      if (uart_tx !== frame_bit(8'h55, k / 4)) begin
        failures++; $display("FAIL t1_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(8'h55, k / 4));
      end
    end
    step();
    checks += 2;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t1_idle_tx: got %b expected 1", uart_tx); end
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t1_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    do_reset();
    set_div(2);
    tx_en_in = 1'b1; tx_char_in = bytes[0];
    step();
    tx_char_in = bytes[1];
    step();
    tx_en_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      checks++;
      if (uart_tx !== frame_bit(bytes[k / 20], (k % 20) / 2)) begin
        failures++; $display("FAIL t2_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(bytes[k / 20], (k % 20) / 2));
      end
    end
    step();
    checks += 2;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t2_idle_tx: got %b expected 1", uart_tx); end
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t2_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [9];
    bytes[0] = 8'hFF;
    for (int i = 1; i < 9; i++) bytes[i] = 8'(i * 8'h11);
    do_reset();
    set_div(100);
    tx_en_in = 1'b1; tx_char_in = bytes[0];
    step();
    for (int i = 1; i <= 9; i++) begin
      tx_char_in = 8'(i * 8'h11);
      step();
      if (i == 8) begin
        checks += 2;
        if (tx_fifo_full_out !== 1'b1) begin failures++; $display("FAIL t3_full: got %b expected 1", tx_fifo_full_out); end
        if (tx_overrun_out !== 1'b0) begin failures++; $display("FAIL t3_no_overrun_yet: got %b expected 0", tx_overrun_out); end
      end
    end
    checks += 2;
    if (tx_overrun_out !== 1'b1) begin failures++; $display("FAIL t3_overrun: got %b expected 1", tx_overrun_out); end
    if (tx_fifo_full_out !== 1'b1) begin failures++; $display("FAIL t3_still_full: got %b expected 1", tx_fifo_full_out); end
    tx_char_in = 8'hEE; tx_overrun_clear = 1'b1;
    step();
    tx_en_in = 1'b0;
    checks++;
    if (tx_overrun_out !== 1'b1) begin failures++; $display("FAIL t3_set_wins: got %b expected 1", tx_overrun_out); end
    step();
    tx_overrun_clear = 1'b0;
    checks++;
    if (tx_overrun_out !== 1'b0) begin failures++; $display("FAIL t3_cleared: got %b expected 0", tx_overrun_out); end
    for (int k = 10; k < 9000; k++) begin
      if (k > 10) step();
      checks++;
      if (uart_tx !== frame_bit(bytes[k / 1000], (k % 1000) / 100)) begin
        failures++; $display("FAIL t3_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(bytes[k / 1000], (k % 1000) / 100));
      end
    end
    step();
    checks++;
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t3_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] bytes [9];
    for (int i = 0; i < 8; i++) bytes[i] = 8'((i + 1) * 8'h11);
    bytes[8] = 8'h96;
    do_reset();
    set_div(2);
    tx_en_in = 1'b1; tx_char_in = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      tx_char_in = bytes[i];
      step();
    end
    tx_en_in = 1'b0;
    checks++;
    if (tx_fifo_full_out !== 1'b1) begin failures++; $display("FAIL t4_full: got %b expected 1", tx_fifo_full_out); end
    for (int i = 0; i < 12; i++) step();
    tx_en_in = 1'b1; tx_char_in = bytes[8];
    step();
    tx_en_in = 1'b0;
    checks += 3;
    if (tx_fifo_full_out !== 1'b1) begin failures++; $display("FAIL t4_full_after_pop: got %b expected 1", tx_fifo_full_out); end
    if (tx_overrun_out !== 1'b0) begin failures++; $display("FAIL t4_overrun: got %b expected 0", tx_overrun_out); end
    if (uart_tx !== 1'b0) begin failures++; $display("FAIL t4_next_start: got %b expected 0", uart_tx); end
    for (int k = 0; k < 180; k++) begin
      if (k > 0) step();
      checks++;
      if (uart_tx !== frame_bit(bytes[k / 20], (k % 20) / 2)) begin
        failures++; $display("FAIL t4_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(bytes[k / 20], (k % 20) / 2));
      end
    end
    step();
    checks++;
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t4_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_divisor_change();
    logic exp;
    do_reset();
    set_div(4);
    tx_en_in = 1'b1; tx_char_in = 8'h0F;
    step();
    tx_char_in = 8'hF0;
    step();
    tx_en_in = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (k > 0) step();
      exp = (k < 40) ? frame_bit(8'h0F, k / 4) : frame_bit(8'hF0, (k - 40) / 8);
      checks++;
      if (uart_tx !== exp) begin
        failures++; $display("FAIL t5_line k=%0d: got %b expected %b", k, uart_tx, exp);
      end
      divisor_set = (k == 10);
      divisor_reg = 32'd8;
    end
    divisor_set = 1'b0;
    step();
    checks += 2;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t5_idle_tx: got %b expected 1", uart_tx); end
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t5_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    set_div(4);
    tx_en_in = 1'b1; tx_char_in = 8'h81;
    step();
    tx_char_in = 8'h22;
    step();
    tx_en_in = 1'b0;
    for (int k = 1; k <= 17; k++) step();
    checks++;
    if (uart_tx !== 1'b0) begin failures++; $display("FAIL t6_bit3_low: got %b expected 0", uart_tx); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 4;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t6_tx: got %b expected 1", uart_tx); end
    if (tx_fifo_empty_out !== 1'b1) begin failures++; $display("FAIL t6_empty: got %b expected 1", tx_fifo_empty_out); end
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t6_busy: got %b expected 0", tx_busy_out); end
    if (tx_fifo_full_out !== 1'b0) begin failures++; $display("FAIL t6_full: got %b expected 0", tx_fifo_full_out); end
    step();
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL t6_stays_idle: got %b expected 1", uart_tx); end
    // Divisor is back to 1 after reset
    tx_en_in = 1'b1; tx_char_in = 8'h5A;
    step();
    tx_en_in = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      checks++;
      if (uart_tx !== frame_bit(8'h5A, k)) begin
        failures++; $display("FAIL t6_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(8'h5A, k));
      end
    end
    step();
    checks++;
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL t6_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  task automatic test_divisor_zero();
    do_reset();
    set_div(4);
    set_div(0);
    tx_en_in = 1'b1; tx_char_in = 8'hC3;
    step();
    tx_en_in = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      checks++;
      if (uart_tx !== frame_bit(8'hC3, k)) begin
        failures++; $display("FAIL div0_line k=%0d: got %b expected %b", k, uart_tx, frame_bit(8'hC3, k));
      end
    end
    step();
    checks++;
    if (tx_busy_out !== 1'b0) begin failures++; $display("FAIL div0_idle_busy: got %b expected 0", tx_busy_out); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_full_with_pop();
    test_divisor_change();
    test_reset_mid_frame();
    test_divisor_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
